mouse_port: RTL and testbench



---
 rtl/bk_port_pkg.sv | 21 ++
 rtl/mouse_axis.sv | 109 ++++++++++
 rtl/mouse_port.sv | 116 +++++++++++
 tb/tb_mouse_port.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bk_port_pkg.sv
// rtl/bk_port_pkg.sv - shared constants and types for the BK-0011M 177714 mouse port
//
// Purpose: bit positions of the 177714 read word, the enable bit of the
//          write word, and the port ownership type (joystick or mouse).
// Ports:   none (package).
package bk_port_pkg;

  localparam int DIR_UP     = 0;
  localparam int DIR_RIGHT  = 1;
  localparam int DIR_DOWN   = 2;
  localparam int DIR_LEFT   = 3;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 6;
  localparam int ENABLE_BIT = 3;

  typedef enum logic {
    JOY   = 1'b0,
    MOUSE = 1'b1
  } port_mode_t;

endpackage

// File: rtl/mouse_axis.sv
// rtl/mouse_axis.sv - one saturating motion accumulator with its pos/neg direction pair
//
// Purpose: accumulates signed 9-bit deltas into an ACC_W-bit saturating
//          accumulator and raises one direction bit once the magnitude
//          exceeds THRESH, paying THRESH+1 back out of the accumulator.
// Config:  MOUSE_ACCEL_EN - when defined, deltas of magnitude >= 16 are doubled.
// Ports:   clk_i, rst_ni    clock, asynchronous active-low reset
//          clear_i          clears accumulator and both direction bits
//          add_en_i         add delta_i this cycle
//          delta_i [8:0]    two's-complement motion delta
//          consume_i        CPU read: drop the direction bits
//          pos_o, neg_o     direction bits (at most one set)
module mouse_axis #(
  parameter int THRESH = 3,
  parameter int ACC_W  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       add_en_i,
  input  logic [8:0] delta_i,
  input  logic       consume_i,
  output logic       pos_o,
  output logic       neg_o
);

  // Wide enough to hold accumulator plus a doubled 9-bit delta without wrap.
  localparam int SW = ((ACC_W > 9) ? ACC_W : 9) + 3;
  localparam logic signed [SW-1:0] MAXV  = SW'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV  = -MAXV - SW'(1);
  localparam logic signed [SW-1:0] THR   = SW'(THRESH);
  localparam logic signed [SW-1:0] NTHR  = -THR;
  localparam logic signed [SW-1:0] STEP  = SW'(THRESH + 1);
  localparam logic signed [SW-1:0] BIG   = SW'(15);
  localparam logic signed [SW-1:0] NBIG  = -BIG;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    pos_q, pos_d;
  logic                    neg_q, neg_d;

  logic signed [SW-1:0] delta_ext, scaled, acc_ext, base, sum;
  logic                 set_pos, set_neg;

  always_comb begin
    delta_ext = {{(SW-9){delta_i[8]}}, delta_i};
`ifdef MOUSE_ACCEL_EN
    scaled = ((delta_ext > BIG) || (delta_ext < NBIG)) ? (delta_ext <<< 1) : delta_ext;
`else
    scaled = delta_ext;
`endif
    acc_ext = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};

    // A new bit is only raised while neither bit of this axis is held.
    set_pos = !pos_q && !neg_q && (acc_ext > THR);
    set_neg = !pos_q && !neg_q && (acc_ext < NTHR);

    base = acc_ext;
    if (set_pos) begin
      base = acc_ext - STEP;
    end else if (set_neg) begin
      base = acc_ext + STEP;
    end
    sum = add_en_i ? (base + scaled) : base;

    if (sum > MAXV) begin
      acc_d = MAXV[ACC_W-1:0];
    end else if (sum < MINV) begin
      acc_d = MINV[ACC_W-1:0];
    end else begin
      acc_d = sum[ACC_W-1:0];
    end

    // A set in the same cycle as a read beats the read.
    pos_d = pos_q;
    neg_d = neg_q;
    if (set_pos) begin
      pos_d = 1'b1;
    end else if (consume_i) begin
      pos_d = 1'b0;
    end
    if (set_neg) begin
      neg_d = 1'b1;
    end else if (consume_i) begin
      neg_d = 1'b0;
    end

    if (clear_i) begin
      acc_d = '0;
      pos_d = 1'b0;
      neg_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  assign pos_o = pos_q;
  assign neg_o = neg_q;

endmodule

// File: rtl/mouse_port.sv
// rtl/mouse_port.sv - PS/2 mouse packets to BK-0011M 177714 mouse protocol
//
// Purpose: accumulates X/Y motion into one-shot direction bits consumed by
//          CPU reads, registers the buttons, and muxes mouse or joystick
//          state onto the register-14 read word.
// Config:  MOUSE_ACCEL_EN - doubles large deltas inside mouse_axis.
// Ports:   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//          mouse_strobe              new packet valid (one cycle)
//          pointer_dx/dy [8:0]       signed motion deltas
//          left_btn, right_btn       mouse button levels
//          joystick [7:0]            OR of joystick buttons
//          port_we, port_sel0        CPU write strobe / low-byte select
//          port_din [15:0]           CPU write data (bit 3 = mouse enable)
//          port_rd                   CPU read strobe, consumes direction bits
//          port_data [15:0]          read word to the CPU
//          mouse_mode                1 = mouse owns the port
module mouse_port
  import bk_port_pkg::*;
#(
  parameter int THRESH = 3,
  parameter int ACC_W  = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        mouse_strobe,
  input  logic [8:0]  pointer_dx,
  input  logic [8:0]  pointer_dy,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic [7:0]  joystick,
  input  logic        port_we,
  input  logic        port_sel0,
  input  logic [15:0] port_din,
  input  logic        port_rd,
  output logic [15:0] port_data,
  output logic        mouse_mode
);

  logic       enable_q, enable_d;
  port_mode_t mode_q, mode_d;
  logic       left_q, right_q;
  logic       wr_en, wr_clear, add_en;
  logic [3:0] dir;
  logic       unused_din;

  assign unused_din = ^{port_din[15:ENABLE_BIT+1], port_din[ENABLE_BIT-1:0]};

  assign wr_en    = port_we & port_sel0;
  assign wr_clear = wr_en & ~port_din[ENABLE_BIT];
  // A disabling write in the same cycle drops the packet.
  assign add_en   = enable_q & mouse_strobe & ~wr_clear;

  mouse_axis #(.THRESH(THRESH), .ACC_W(ACC_W)) u_axis_x (
    .clk_i     (wb_clk),
    .rst_ni    (wb_rst_n),
    .clear_i   (wr_clear),
    .add_en_i  (add_en),
    .delta_i   (pointer_dx),
    .consume_i (port_rd),
    .pos_o     (dir[DIR_RIGHT]),
    .neg_o     (dir[DIR_LEFT])
  );

  mouse_axis #(.THRESH(THRESH), .ACC_W(ACC_W)) u_axis_y (
    .clk_i     (wb_clk),
    .rst_ni    (wb_rst_n),
    .clear_i   (wr_clear),
    .add_en_i  (add_en),
    .delta_i   (pointer_dy),
    .consume_i (port_rd),
    .pos_o     (dir[DIR_UP]),
    .neg_o     (dir[DIR_DOWN])
  );

  always_comb begin
    enable_d = enable_q;
    if (wr_en) begin
      enable_d = port_din[ENABLE_BIT];
    end
    // Any joystick activity takes the port back from the mouse.
    mode_d = mode_q;
    if (joystick != 8'h00) begin
      mode_d = JOY;
    end else if (mouse_strobe) begin
      mode_d = MOUSE;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      enable_q <= 1'b0;
      mode_q   <= JOY;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      left_q   <= left_btn;
      right_q  <= right_btn;
    end
  end

  always_comb begin
    port_data = 16'h0000;
    if (mode_q == MOUSE) begin
      port_data[3:0]       = dir;
      port_data[BTN_LEFT]  = left_q;
      port_data[BTN_RIGHT] = right_q;
    end else begin
      port_data[7:0] = joystick;
    end
  end

  assign mouse_mode = (mode_q == MOUSE);

endmodule

// File: tb/tb_mouse_port.sv
// tb/tb_mouse_port.sv - directed self-checking bench for mouse_port
module tb_mouse_port;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        mouse_strobe = 1'b0;
  logic [8:0]  pointer_dx = '0;
  logic [8:0]  pointer_dy = '0;
  logic        left_btn = 1'b0;
  logic        right_btn = 1'b0;
  logic [7:0]  joystick = '0;
  logic        port_we = 1'b0;
  logic        port_sel0 = 1'b0;
  logic [15:0] port_din = '0;
  logic        port_rd = 1'b0;
  logic [15:0] port_data;
  logic        mouse_mode;

  int total = 0;
  int bad = 0;

  mouse_port dut (
    .wb_clk       (wb_clk),
    .wb_rst_n     (wb_rst_n),
    .mouse_strobe (mouse_strobe),
    .pointer_dx   (pointer_dx),
    .pointer_dy   (pointer_dy),
    .left_btn     (left_btn),
    .right_btn    (right_btn),
    .joystick     (joystick),
    .port_we      (port_we),
    .port_sel0    (port_sel0),
    .port_din     (port_din),
    .port_rd      (port_rd),
    .port_data    (port_data),
    .mouse_mode   (mouse_mode)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic port_write(input logic [15:0] d);
    port_we = 1'b1; port_sel0 = 1'b1; port_din = d;
    tick();
    port_we = 1'b0; port_sel0 = 1'b0; port_din = '0;
  endtask

  task automatic cpu_read();
    port_rd = 1'b1;
    tick();
    port_rd = 1'b0;
  endtask

  function automatic logic [15:0] acc_x();
    return {8'h00, dut.u_axis_x.acc_q};
  endfunction

  function automatic logic [15:0] acc_y();
    return {8'h00, dut.u_axis_y.acc_q};
  endfunction

  logic [15:0] exp_accel_acc;

  initial begin
`ifdef MOUSE_ACCEL_EN
    exp_accel_acc = 16'd36;
`else
    exp_accel_acc = 16'd16;
`endif
    #12;
    check("reset_data", port_data, 16'h0000);
    check("reset_mode", {15'b0, mouse_mode}, 16'h0000);
    wb_rst_n = 1'b1;
    tick();

    // Enable, then a +5 Y packet raises UP two edges later and leaves 1.
    port_write(16'h0008);
    mouse_strobe = 1'b1; pointer_dy = 9'd5;
    tick();
    mouse_strobe = 1'b0; pointer_dy = '0;
    check("up_n1_data", port_data, 16'h0000);
    check("up_n1_acc", acc_y(), 16'h0005);
    tick();
    check("up_n2_data", port_data, 16'h0001);
    check("up_n2_acc", acc_y(), 16'h0001);
    cpu_read();
    check("up_read", port_data, 16'h0000);

    // Forty -50 X packets saturate at -128 with LEFT held.
    for (int i = 0; i < 40; i++) begin
      mouse_strobe = 1'b1; pointer_dx = -9'd50;
      tick();
    end
    mouse_strobe = 1'b0; pointer_dx = '0;
    tick();
    check("left_sat_acc", acc_x(), 16'h0080);
    check("left_sat_data", port_data, 16'h0008);
    cpu_read();
    check("left_rd1", port_data, 16'h0000);
    tick();
    check("left_re1_data", port_data, 16'h0008);
    check("left_re1_acc", acc_x(), 16'h0084);
    cpu_read();
    check("left_rd2", port_data, 16'h0000);
    tick();
    check("left_re2_acc", acc_x(), 16'h0088);

    // UP with LEFT held, then disabling write clears everything.
    mouse_strobe = 1'b1; pointer_dy = 9'd5;
    tick();
    mouse_strobe = 1'b0; pointer_dy = '0;
    tick();
    check("both_data", port_data, 16'h0009);
    port_write(16'h0000);
    check("dis_data", port_data, 16'h0000);
    check("dis_accx", acc_x(), 16'h0000);
    check("dis_accy", acc_y(), 16'h0000);
    mouse_strobe = 1'b1; pointer_dy = 9'd100;
    tick();
    mouse_strobe = 1'b0; pointer_dy = '0;
    tick();
    check("dis_ign_acc", acc_y(), 16'h0000);
    check("dis_ign_data", port_data, 16'h0000);
    check("dis_mode", {15'b0, mouse_mode}, 16'h0001);

    // Joystick beats a simultaneous strobe.
    joystick = 8'h04; mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
    check("joy_mode", {15'b0, mouse_mode}, 16'h0000);
    check("joy_data", port_data, 16'h0004);
    joystick = 8'h00; mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
    check("joy_rel_mode", {15'b0, mouse_mode}, 16'h0001);
    check("joy_rel_data", port_data, 16'h0000);

    // Buttons appear regardless of enable.
    left_btn = 1'b1; right_btn = 1'b1;
    tick();
    check("btn_dis", port_data, 16'h0060);
    port_write(16'h0008);
    check("btn_en", port_data, 16'h0060);

    // Disabling write in the same cycle as a packet drops the packet.
    port_we = 1'b1; port_sel0 = 1'b1; port_din = 16'h0000;
    mouse_strobe = 1'b1; pointer_dy = 9'd100;
    tick();
    port_we = 1'b0; port_sel0 = 1'b0; mouse_strobe = 1'b0; pointer_dy = '0;
    tick();
    check("wr_wins_acc", acc_y(), 16'h0000);
    check("wr_wins_data", port_data, 16'h0060);

    // +20 X: 16 left unscaled, 36 with acceleration; RIGHT set either way.
    port_write(16'h0008);
    mouse_strobe = 1'b1; pointer_dx = 9'd20;
    tick();
    mouse_strobe = 1'b0; pointer_dx = '0;
    tick();
    check("right_acc", acc_x(), exp_accel_acc);
    check("right_data", port_data, 16'h0062);

    // Reset in the middle of a packet takes effect at once and leaves nothing.
    mouse_strobe = 1'b1; pointer_dy = 9'd5;
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("rst_mid_data", port_data, 16'h0000);
    check("rst_mid_mode", {15'b0, mouse_mode}, 16'h0000);
    tick();
    mouse_strobe = 1'b0; pointer_dy = '0;
    wb_rst_n = 1'b1;
    tick();
    check("rst_after_accy", acc_y(), 16'h0000);
    check("rst_after_accx", acc_x(), 16'h0000);
    check("rst_after_data", port_data, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
